// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : UART receive-side controller. It gates the receiver datapath
//             through a two-state enable FSM, buffers received bytes in a
//             small FIFO with a sticky overflow flag, and raises a one-shot
//             idle timeout after traffic stops.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [7:0]               rx_data,
    input  logic                     rx_data_ready,
    input  logic                     pop,
    output logic                     rx_enable,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     rx_buf_full,
    output logic                     overflow,
    output logic                     idle_timeout
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX   = c_TMO_W'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------------
    // Enable FSM encoding
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_OFF    = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------------
    logic [7:0]          r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;

    // Idle timer state: counter, one-shot arm flag, registered pulse
    logic [c_TMO_W-1:0]  r_idle_cnt;
    logic                r_idle_armed;
    logic                r_idle_pulse;

    // Per-edge decisions
    logic w_active;
    logic w_full;
    logic w_not_empty;
    logic w_push;
    logic w_rd_en;
    logic w_wr_en;
    logic w_drop;

    assign w_active    = (r_state == ST_ACTIVE);
    assign w_full      = (r_count == c_DEPTH_CNT);
    assign w_not_empty = (r_count != '0);

    // A strobe is taken only in ACTIVE; flush wins over everything.
    assign w_push  = w_active && rx_data_ready && !flush;
    // Pop on an empty FIFO is ignored, which also covers push+pop at count 0.
    assign w_rd_en = pop && w_not_empty && !flush;
    // When full, a push only lands if the same edge frees the head slot.
    assign w_wr_en = w_push && (!w_full || w_rd_en);
    assign w_drop  = w_push && w_full && !w_rd_en;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_enable    = w_active;
    assign rd_data      = r_mem[r_rd_ptr];
    assign rd_valid     = w_not_empty;
    assign count        = r_count;
    assign rx_buf_full  = w_full;
    assign overflow     = r_overflow;
    assign idle_timeout = r_idle_pulse;

    // State register for the enable FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: enable without flush turns on, disable or flush turns off
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_OFF: begin
                if (enable && !flush) begin
                    w_state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!enable || flush) begin
                    w_state_next = ST_OFF;
                end
            end
            default: begin
                w_state_next = ST_OFF;
            end
        endcase
    end

    // Byte storage; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Idle timer: counts while ACTIVE with data held, fires once per push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle_cnt   <= '0;
            r_idle_armed <= 1'b0;
            r_idle_pulse <= 1'b0;
        end else if (flush) begin
            r_idle_cnt   <= '0;
            r_idle_armed <= 1'b0;
            r_idle_pulse <= 1'b0;
        end else if (w_push) begin
            r_idle_cnt   <= '0;
            r_idle_armed <= 1'b1;
            r_idle_pulse <= 1'b0;
        end else if (w_active && w_not_empty) begin
            if (r_idle_cnt != c_TMO_MAX) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
                // Fire on the edge where the counter lands on its limit
                if ((r_idle_cnt + 1'b1) == c_TMO_MAX && r_idle_armed) begin
                    r_idle_pulse <= 1'b1;
                    r_idle_armed <= 1'b0;
                end else begin
                    r_idle_pulse <= 1'b0;
                end
            end else begin
                r_idle_pulse <= 1'b0;
            end
        end else begin
            r_idle_cnt   <= '0;
            r_idle_pulse <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Directed self-checking bench for uart_rx_ctrl with
//             hand-computed expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int DEPTH          = 8;
    localparam int TIMEOUT_CYCLES = 20;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       flush;
    logic [7:0] rx_data;
    logic       rx_data_ready;
    logic       pop;
    logic       rx_enable;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] count;
    logic       rx_buf_full;
    logic       overflow;
    logic       idle_timeout;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_ctrl #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .flush         (flush),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .pop           (pop),
        .rx_enable     (rx_enable),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .count         (count),
        .rx_buf_full   (rx_buf_full),
        .overflow      (overflow),
        .idle_timeout  (idle_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1 time unit before sampling or driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
    endtask

    task automatic pop_byte();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    // Flush (drops to OFF) then one more edge with enable=1 to return to ACTIVE
    task automatic flush_and_reenable();
        enable = 1'b1;
        flush  = 1'b1;
        tick();
        flush  = 1'b0;
        tick();
    endtask

    int pulses;
    int pulse_at;

    initial begin
        rst           = 1'b0;
        enable        = 1'b0;
        flush         = 1'b0;
        rx_data       = 8'h00;
        rx_data_ready = 1'b0;
        pop           = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("rst_rx_enable", rx_enable, 0);
        check("rst_count", count, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_full", rx_buf_full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_idle", idle_timeout, 0);
        rst = 1'b1;
        tick();
        check("off_after_rst", rx_enable, 0);

        // ---------------- basic receive and in-order drain ----------------
        enable = 1'b1;
        tick();
        check("enable_latency", rx_enable, 1);
        push_byte(8'h41);
        check("push_latency_valid", rd_valid, 1);
        check("push_latency_data", rd_data, 8'h41);
        push_byte(8'h42);
        push_byte(8'h43);
        check("three_head", rd_data, 8'h41);
        check("three_count", count, 3);
        check("pop1_data", rd_data, 8'h41);
        pop_byte();
        check("pop2_data", rd_data, 8'h42);
        pop_byte();
        check("pop3_data", rd_data, 8'h43);
        pop_byte();
        check("drained_valid", rd_valid, 0);
        check("drained_count", count, 0);
        pop_byte();
        check("pop_empty_count", count, 0);

        // ---------------- overflow: nine strobes into depth 8 ----------------
        for (int i = 1; i <= 9; i++) begin
            push_byte(8'(i));
            if (i == 8) begin
                check("full_at_8", rx_buf_full, 1);
                check("no_ovf_at_8", overflow, 0);
            end
        end
        check("ovf_full", rx_buf_full, 1);
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 8);
        for (int i = 1; i <= 8; i++) begin
            check("ovf_retained", rd_data, 32'(i));
            pop_byte();
        end
        check("ovf_ninth_dropped", rd_valid, 0);
        check("ovf_sticky", overflow, 1);

        // ---------------- full with simultaneous push and pop ----------------
        flush_and_reenable();
        check("flush_clears_ovf", overflow, 0);
        check("reenabled", rx_enable, 1);
        for (int i = 0; i < 8; i++) push_byte(8'(8'h11 + i));
        rx_data       = 8'hAA;
        rx_data_ready = 1'b1;
        pop           = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        pop           = 1'b0;
        check("pp_count", count, 8);
        check("pp_overflow", overflow, 0);
        check("pp_head", rd_data, 8'h12);
        for (int i = 0; i < 7; i++) begin
            check("pp_drain", rd_data, 32'(8'h12 + i));
            pop_byte();
        end
        check("pp_tail", rd_data, 8'hAA);
        pop_byte();
        check("pp_empty", rd_valid, 0);

        // ---------------- idle timeout ----------------
        for (int r = 0; r < 2; r++) begin
            push_byte(8'(8'h55 + r));
            check("idle_after_push", idle_timeout, 0);
            pulses   = 0;
            pulse_at = -1;
            for (int k = 1; k <= TIMEOUT_CYCLES + 15; k++) begin
                tick();
                if (idle_timeout) begin
                    pulses++;
                    pulse_at = k;
                end
            end
            check("idle_pulses", pulses, 1);
            check("idle_pulse_cycle", pulse_at, TIMEOUT_CYCLES);
        end
        check("idle_count_kept", count, 2);
        pop_byte();
        pop_byte();

        // ---------------- flush versus disable with five bytes ----------------
        for (int i = 0; i < 9; i++) push_byte(8'(8'h61 + i));
        for (int i = 0; i < 3; i++) pop_byte();
        check("pre_flush_count", count, 5);
        check("pre_flush_ovf", overflow, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_count", count, 0);
        check("flush_ovf", overflow, 0);
        check("flush_rx_enable", rx_enable, 0);
        tick();
        for (int i = 0; i < 9; i++) push_byte(8'(8'h61 + i));
        for (int i = 0; i < 3; i++) pop_byte();
        enable = 1'b0;
        tick();
        check("dis_count", count, 5);
        check("dis_ovf", overflow, 1);
        check("dis_rx_enable", rx_enable, 0);
        check("dis_head", rd_data, 8'h64);
        push_byte(8'h77);
        check("off_strobe_ignored", count, 5);
        pop_byte();
        check("off_drain_data", rd_data, 8'h65);
        check("off_drain_count", count, 4);

        // ---------------- asynchronous reset mid-cycle ----------------
        flush_and_reenable();
        for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i));
        check("pre_rst_count", count, 4);
        #2 rst = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_rx_enable", rx_enable, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_full", rx_buf_full, 0);
        check("arst_overflow", overflow, 0);
        check("arst_idle", idle_timeout, 0);
        #2 rst = 1'b1;
        enable = 1'b0;
        tick();
        check("post_rst_count", count, 0);
        check("post_rst_off", rx_enable, 0);
        enable = 1'b1;
        tick();
        check("post_rst_resume", rx_enable, 1);
        check("post_rst_empty", rd_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
